// File: rtl/psram_line_fetcher_pkg.sv
// Shared types and constants for the PSRAM scanline prefetcher.
// Fetch FSM encoding, PSRAM address width and word-address helper.
package psram_line_fetcher_pkg;

  localparam int unsigned PSRAM_AW = 22;

  // Byte addresses are word-aligned; bit 0 of the supplied base is dropped.
  localparam logic [PSRAM_AW-1:0] WordMask = {{(PSRAM_AW - 1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitData
  } fetch_state_e;

  function automatic logic [PSRAM_AW-1:0] word_addr(input logic [PSRAM_AW-1:0] base,
                                                    input logic [PSRAM_AW-1:0] idx);
    return base + (idx << 1);
  endfunction

endpackage

// File: rtl/psram_line_fetcher_line_buf.sv
// Simple dual-port line buffer: one synchronous write port, one synchronous read port.
// No reset on the array or read register so it maps onto block RAM.
module psram_line_fetcher_line_buf #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/psram_line_fetcher.sv
// Ping-pong scanline prefetcher: fills the back half of a line buffer from PSRAM one word at a
// time while the pixel pipeline reads the front half; swap exchanges the halves.
module psram_line_fetcher
  import psram_line_fetcher_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 320,
  parameter int unsigned BUF_AW     = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_req,
  input  logic [PSRAM_AW-1:0] line_base,
  input  logic                swap,
  input  logic [BUF_AW-1:0]   pix_addr,
  output logic [15:0]         pix_data,
  output logic                fetch_busy,
  output logic                fetch_done,
  output logic                overrun,
  output logic                mem_read,
  output logic [PSRAM_AW-1:0] mem_addr,
  input  logic                mem_busy,
  input  logic [15:0]         mem_dout
);

  localparam logic [BUF_AW-1:0] LastIdx = BUF_AW'(LINE_WORDS - 1);

  fetch_state_e        state_q;
  logic [BUF_AW-1:0]   idx_q;
  logic [PSRAM_AW-1:0] base_q;
  logic                abort_q;
  logic                sel_q;
  logic                rng_ok_q;

  logic                fetch_active;
  logic                buf_we;
  logic [BUF_AW:0]     buf_waddr;
  logic [BUF_AW:0]     buf_raddr;
  logic [15:0]         buf_rdata;

  assign fetch_active = (state_q != StIdle);
  // A swap on the completing cycle aborts too, so its word must not land in the new front half.
  assign buf_we    = (state_q == StWaitData) && !mem_busy && !abort_q && !swap;
  assign buf_waddr = {~sel_q, idx_q};
  assign buf_raddr = {sel_q, pix_addr};
  assign pix_data  = rng_ok_q ? buf_rdata : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      base_q     <= '0;
      abort_q    <= 1'b0;
      sel_q      <= 1'b0;
      rng_ok_q   <= 1'b0;
      fetch_busy <= 1'b0;
      fetch_done <= 1'b0;
      overrun    <= 1'b0;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
    end else begin
      fetch_done <= 1'b0;
      overrun    <= 1'b0;
      mem_read   <= 1'b0;
      rng_ok_q   <= (32'(pix_addr) < LINE_WORDS);

      if (swap) begin
        sel_q <= ~sel_q;
      end
      if ((swap && fetch_active && !abort_q) || (line_req && fetch_active)) begin
        overrun <= 1'b1;
      end
      if (swap && fetch_active) begin
        abort_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (line_req) begin
            base_q     <= line_base & WordMask;
            idx_q      <= '0;
            abort_q    <= 1'b0;
            fetch_busy <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (swap || abort_q) begin
            abort_q    <= 1'b0;
            fetch_busy <= 1'b0;
            state_q    <= StIdle;
          end else if (!mem_busy) begin
            mem_read <= 1'b1;
            mem_addr <= word_addr(base_q, PSRAM_AW'(idx_q));
            state_q  <= StWaitStart;
          end
        end
        StWaitStart: begin
          if (mem_busy) begin
            state_q <= StWaitData;
          end
        end
        StWaitData: begin
          if (!mem_busy) begin
            if (abort_q || swap) begin
              abort_q    <= 1'b0;
              fetch_busy <= 1'b0;
              state_q    <= StIdle;
            end else if (idx_q == LastIdx) begin
              fetch_done <= 1'b1;
              fetch_busy <= 1'b0;
              state_q    <= StIdle;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StIssue;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  psram_line_fetcher_line_buf #(
    .AW(BUF_AW + 1),
    .DW(16)
  ) u_line_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(buf_waddr),
    .wdata(mem_dout),
    .raddr(buf_raddr),
    .rdata(buf_rdata)
  );

endmodule
